// File: rtl/exe_stage_top.sv
// ---------------------------------------------------------------------------
// exe_stage_top
// Execute stage of the in-order DRAC integer pipeline, between register-read
// and write-back.
//
// Function:
//   - 64-bit ALU (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
//     Result is registered: latency 1 cycle, throughput 1 per cycle.
//   - Load/store issue to the data-memory interface through a small
//     IDLE -> REQ -> WAIT state machine. Upstream is stalled (dmem_lock_o)
//     while an access is outstanding.
//   - One registered result record per instruction to write-back.
//
// Ports:
//   clk_i, rstn_i            clock (rising edge), synchronous reset (1 = reset)
//   valid_i, unit_i          instruction present, functional unit
//                            (0 ALU, 1 LOAD, 2 STORE, 3 none)
//   alu_op_i, use_imm_i      ALU operation, operand B select
//   imm_i, data_rs1_i,
//   data_rs2_i, rd_i         operands and destination register
//   mem_size_i               0 byte, 1 half, 2 word, 3 dword
//   io_base_addr_i           addresses >= this are IO
//   dmem_req_*_o             request channel to the data cache
//   dmem_resp_*_i            response channel (valid, data, nack, replay)
//   dmem_xcpt_*_i            misaligned / page-fault exceptions
//   dmem_req_kill_o          one-cycle pulse when an exception aborts
//   dmem_lock_o              stall upstream
//   wb_*_o                   registered write-back record
//   dbg_state_o              current memory FSM state (0 IDLE, 1 REQ, 2 WAIT)
//   dbg_io_access_o          current/last memory access targets IO space
//
// Handshake: a request transfers on a rising edge where dmem_req_valid_o and
// dmem_req_ready_i are both 1. dmem_req_valid_o is held, with stable
// address/data/tag, until that transfer or until an exception aborts it.
// A nack or replay in WAIT sends the FSM back to REQ to reissue the same
// request. Upstream may only present an instruction while dmem_lock_o is 0;
// anything presented while locked is dropped.
// ---------------------------------------------------------------------------
module exe_stage_top #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 40,
    parameter int TAG_W  = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              valid_i,
    input  logic [1:0]        unit_i,
    input  logic [3:0]        alu_op_i,
    input  logic              use_imm_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   data_rs1_i,
    input  logic [XLEN-1:0]   data_rs2_i,
    input  logic [4:0]        rd_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] io_base_addr_i,
    input  logic              dmem_req_ready_i,
    input  logic              dmem_resp_valid_i,
    input  logic [63:0]       dmem_resp_data_i,
    input  logic              dmem_resp_nack_i,
    input  logic              dmem_resp_replay_i,
    input  logic              dmem_xcpt_ma_st_i,
    input  logic              dmem_xcpt_ma_ld_i,
    input  logic              dmem_xcpt_pf_st_i,
    input  logic              dmem_xcpt_pf_ld_i,
    output logic              dmem_req_valid_o,
    output logic [4:0]        dmem_req_cmd_o,
    output logic [ADDR_W-1:0] dmem_req_addr_o,
    output logic [1:0]        dmem_op_type_o,
    output logic [63:0]       dmem_req_data_o,
    output logic [TAG_W-1:0]  dmem_req_tag_o,
    output logic              dmem_req_invalidate_lr_o,
    output logic              dmem_req_kill_o,
    output logic              dmem_lock_o,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [XLEN-1:0]   wb_result_o,
    output logic              wb_xcpt_o,
    output logic [3:0]        wb_xcpt_cause_o,
    output logic [1:0]        dbg_state_o,
    output logic              dbg_io_access_o
);

    // -----------------------------------------------------------------------
    // Encodings
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] UNIT_ALU   = 2'd0;
    localparam logic [1:0] UNIT_LOAD  = 2'd1;
    localparam logic [1:0] UNIT_STORE = 2'd2;
    localparam logic [1:0] UNIT_NONE  = 2'd3;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    localparam logic [3:0] CAUSE_MA_LD = 4'd4;
    localparam logic [3:0] CAUSE_MA_ST = 4'd6;
    localparam logic [3:0] CAUSE_PF_LD = 4'd13;
    localparam logic [3:0] CAUSE_PF_ST = 4'd15;

    // -----------------------------------------------------------------------
    // State and latched memory instruction
    // -----------------------------------------------------------------------
    state_t            state;
    logic [4:0]        lat_rd;
    logic [1:0]        lat_size;
    logic              lat_is_store;
    logic [ADDR_W-1:0] lat_addr;
    logic [63:0]       lat_data;
    logic              lat_io;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [XLEN-1:0]   op_b;
    logic [5:0]        shamt;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   load_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              is_mem_unit;
    logic              any_xcpt;
    logic [3:0]        xcpt_cause;
    logic              reissue;

    assign op_b        = use_imm_i ? imm_i : data_rs2_i;
    assign shamt       = op_b[5:0];
    assign is_mem_unit = (unit_i == UNIT_LOAD) || (unit_i == UNIT_STORE);
    // Effective address is only ever needed to ADDR_W bits, so the adder is
    // kept at that width instead of truncating a full XLEN sum.
    assign mem_addr    = data_rs1_i[ADDR_W-1:0] + imm_i[ADDR_W-1:0];
    assign any_xcpt    = dmem_xcpt_ma_ld_i | dmem_xcpt_ma_st_i |
                         dmem_xcpt_pf_ld_i | dmem_xcpt_pf_st_i;
    assign reissue     = dmem_resp_nack_i | dmem_resp_replay_i;

    always_comb begin
        alu_result = '0;
        case (alu_op_i)
            OP_ADD:  alu_result = data_rs1_i + op_b;
            OP_SUB:  alu_result = data_rs1_i - op_b;
            OP_SLL:  alu_result = data_rs1_i << shamt;
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}},
                                   ($signed(data_rs1_i) < $signed(op_b))};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (data_rs1_i < op_b)};
            OP_XOR:  alu_result = data_rs1_i ^ op_b;
            OP_SRL:  alu_result = data_rs1_i >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(data_rs1_i) >>> shamt);
            OP_OR:   alu_result = data_rs1_i | op_b;
            OP_AND:  alu_result = data_rs1_i & op_b;
            default: alu_result = '0;
        endcase
    end

    // Sign-extend load data according to the latched access size.
    always_comb begin
        load_data = '0;
        case (lat_size)
            2'd0:    load_data = {{(XLEN-8){dmem_resp_data_i[7]}},
                                  dmem_resp_data_i[7:0]};
            2'd1:    load_data = {{(XLEN-16){dmem_resp_data_i[15]}},
                                  dmem_resp_data_i[15:0]};
            2'd2:    load_data = {{(XLEN-32){dmem_resp_data_i[31]}},
                                  dmem_resp_data_i[31:0]};
            default: load_data = dmem_resp_data_i;
        endcase
    end

    // Only one exception is expected at a time; the fixed priority just makes
    // the result deterministic if the cache ever raises several.
    always_comb begin
        xcpt_cause = '0;
        if (dmem_xcpt_ma_ld_i)      xcpt_cause = CAUSE_MA_LD;
        else if (dmem_xcpt_ma_st_i) xcpt_cause = CAUSE_MA_ST;
        else if (dmem_xcpt_pf_ld_i) xcpt_cause = CAUSE_PF_LD;
        else if (dmem_xcpt_pf_st_i) xcpt_cause = CAUSE_PF_ST;
    end

    // -----------------------------------------------------------------------
    // Main sequential block: memory FSM plus the write-back register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            state           <= S_IDLE;
            lat_rd          <= '0;
            lat_size        <= '0;
            lat_is_store    <= 1'b0;
            lat_addr        <= '0;
            lat_data        <= '0;
            lat_io          <= 1'b0;
            wb_valid_o      <= 1'b0;
            wb_rd_o         <= '0;
            wb_result_o     <= '0;
            wb_xcpt_o       <= 1'b0;
            wb_xcpt_cause_o <= '0;
            dmem_req_kill_o <= 1'b0;
        end else begin
            // Write-back record and kill are single-cycle pulses.
            wb_valid_o      <= 1'b0;
            wb_xcpt_o       <= 1'b0;
            wb_xcpt_cause_o <= '0;
            dmem_req_kill_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        case (unit_i)
                            UNIT_ALU: begin
                                wb_valid_o  <= 1'b1;
                                wb_rd_o     <= rd_i;
                                wb_result_o <= alu_result;
                            end
                            UNIT_NONE: begin
                                wb_valid_o  <= 1'b1;
                                wb_rd_o     <= rd_i;
                                wb_result_o <= '0;
                            end
                            default: begin
                                lat_rd       <= rd_i;
                                lat_size     <= mem_size_i;
                                lat_is_store <= (unit_i == UNIT_STORE);
                                lat_addr     <= mem_addr;
                                lat_data     <= data_rs2_i;
                                lat_io       <= (mem_addr >= io_base_addr_i);
                                state        <= S_REQ;
                            end
                        endcase
                    end
                end

                S_REQ: begin
                    if (any_xcpt) begin
                        dmem_req_kill_o <= 1'b1;
                        wb_valid_o      <= 1'b1;
                        wb_rd_o         <= lat_rd;
                        wb_result_o     <= '0;
                        wb_xcpt_o       <= 1'b1;
                        wb_xcpt_cause_o <= xcpt_cause;
                        state           <= S_IDLE;
                    end else if (dmem_req_ready_i) begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // Exception beats a same-cycle response; a nack/replay
                    // beats a same-cycle response because the data is not
                    // to be trusted.
                    if (any_xcpt) begin
                        dmem_req_kill_o <= 1'b1;
                        wb_valid_o      <= 1'b1;
                        wb_rd_o         <= lat_rd;
                        wb_result_o     <= '0;
                        wb_xcpt_o       <= 1'b1;
                        wb_xcpt_cause_o <= xcpt_cause;
                        state           <= S_IDLE;
                    end else if (reissue) begin
                        state <= S_REQ;
                    end else if (dmem_resp_valid_i) begin
                        wb_valid_o  <= 1'b1;
                        wb_rd_o     <= lat_rd;
                        wb_result_o <= lat_is_store ? '0 : load_data;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Request outputs come straight from registers, so they are glitch-free.
    assign dmem_req_valid_o         = (state == S_REQ);
    assign dmem_req_cmd_o           = {4'b0000, lat_is_store};
    assign dmem_req_addr_o          = lat_addr;
    assign dmem_op_type_o           = lat_size;
    assign dmem_req_data_o          = lat_data;
    assign dmem_req_tag_o           = TAG_W'({lat_rd, 3'b000});
    assign dmem_req_invalidate_lr_o = 1'b0;

    // Lock rises combinationally in the accepting cycle so upstream does not
    // advance past the memory op; it is held low throughout reset.
    assign dmem_lock_o = !rstn_i &&
                         ((state != S_IDLE) || (valid_i && is_mem_unit));

    assign dbg_state_o     = state;
    assign dbg_io_access_o = lat_io;

endmodule

// File: tb/tb_exe_stage_top.sv
// Testbench for exe_stage_top: table vectors and randomized ALU traffic
// against a reference model, plus memory sequences with a driver that plays
// the data cache (delays, nacks, replays, exceptions, mid-access reset).
module tb_exe_stage_top;

  localparam logic [1:0] U_ALU   = 2'd0;
  localparam logic [1:0] U_LOAD  = 2'd1;
  localparam logic [1:0] U_STORE = 2'd2;
  localparam logic [1:0] U_NONE  = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_i;
  logic        valid_i;
  logic [1:0]  unit_i;
  logic [3:0]  alu_op_i;
  logic        use_imm_i;
  logic [63:0] imm_i, data_rs1_i, data_rs2_i;
  logic [4:0]  rd_i;
  logic [1:0]  mem_size_i;
  logic [39:0] io_base_addr_i;
  logic        dmem_req_ready_i, dmem_resp_valid_i;
  logic [63:0] dmem_resp_data_i;
  logic        dmem_resp_nack_i, dmem_resp_replay_i;
  logic        dmem_xcpt_ma_st_i, dmem_xcpt_ma_ld_i, dmem_xcpt_pf_st_i, dmem_xcpt_pf_ld_i;
  logic        dmem_req_valid_o;
  logic [4:0]  dmem_req_cmd_o;
  logic [39:0] dmem_req_addr_o;
  logic [1:0]  dmem_op_type_o;
  logic [63:0] dmem_req_data_o;
  logic [7:0]  dmem_req_tag_o;
  logic        dmem_req_invalidate_lr_o, dmem_req_kill_o, dmem_lock_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_result_o;
  logic        wb_xcpt_o;
  logic [3:0]  wb_xcpt_cause_o;
  logic [1:0]  dbg_state_o;
  logic        dbg_io_access_o;

  exe_stage_top dut (
    .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .unit_i(unit_i),
    .alu_op_i(alu_op_i), .use_imm_i(use_imm_i), .imm_i(imm_i),
    .data_rs1_i(data_rs1_i), .data_rs2_i(data_rs2_i), .rd_i(rd_i),
    .mem_size_i(mem_size_i), .io_base_addr_i(io_base_addr_i),
    .dmem_req_ready_i(dmem_req_ready_i), .dmem_resp_valid_i(dmem_resp_valid_i),
    .dmem_resp_data_i(dmem_resp_data_i), .dmem_resp_nack_i(dmem_resp_nack_i),
    .dmem_resp_replay_i(dmem_resp_replay_i),
    .dmem_xcpt_ma_st_i(dmem_xcpt_ma_st_i), .dmem_xcpt_ma_ld_i(dmem_xcpt_ma_ld_i),
    .dmem_xcpt_pf_st_i(dmem_xcpt_pf_st_i), .dmem_xcpt_pf_ld_i(dmem_xcpt_pf_ld_i),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_cmd_o(dmem_req_cmd_o),
    .dmem_req_addr_o(dmem_req_addr_o), .dmem_op_type_o(dmem_op_type_o),
    .dmem_req_data_o(dmem_req_data_o), .dmem_req_tag_o(dmem_req_tag_o),
    .dmem_req_invalidate_lr_o(dmem_req_invalidate_lr_o),
    .dmem_req_kill_o(dmem_req_kill_o), .dmem_lock_o(dmem_lock_o),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_result_o(wb_result_o),
    .wb_xcpt_o(wb_xcpt_o), .wb_xcpt_cause_o(wb_xcpt_cause_o),
    .dbg_state_o(dbg_state_o), .dbg_io_access_o(dbg_io_access_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [4:0]  rd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    longint sa, sb;
    int sh;
    logic [63:0] r;
    sa = longint'(a);
    sb = longint'(b);
    sh = int'(b % 64);
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << sh;
      4'd3: r = (sa < sb) ? 64'd1 : 64'd0;
      4'd4: r = (a < b) ? 64'd1 : 64'd0;
      4'd5: r = a ^ b;
      4'd6: r = a >> sh;
      4'd7: r = 64'(sa >>> sh);
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [1:0] sz);
    byte b8;
    shortint h16;
    int w32;
    longint r;
    b8 = byte'(d[7:0]);
    h16 = shortint'(d[15:0]);
    w32 = int'(d[31:0]);
    case (sz)
      2'd0: r = longint'(b8);
      2'd1: r = longint'(h16);
      2'd2: r = longint'(w32);
      default: r = longint'(d);
    endcase
    return 64'(r);
  endfunction

  function automatic logic [3:0] cause_of(input int xsel);
    case (xsel)
      1: return 4'd4;
      2: return 4'd6;
      3: return 4'd13;
      default: return 4'd15;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    valid_i = 0; unit_i = 0; alu_op_i = 0; use_imm_i = 0; imm_i = 0;
    data_rs1_i = 0; data_rs2_i = 0; rd_i = 0; mem_size_i = 0;
    io_base_addr_i = 40'hFF_0000_0000;
    dmem_req_ready_i = 0; dmem_resp_valid_i = 0; dmem_resp_data_i = 0;
    dmem_resp_nack_i = 0; dmem_resp_replay_i = 0;
    dmem_xcpt_ma_st_i = 0; dmem_xcpt_ma_ld_i = 0; dmem_xcpt_pf_st_i = 0; dmem_xcpt_pf_ld_i = 0;
  endtask

  task automatic clear_resp();
    dmem_req_ready_i = 0; dmem_resp_valid_i = 0; dmem_resp_nack_i = 0; dmem_resp_replay_i = 0;
    dmem_xcpt_ma_st_i = 0; dmem_xcpt_ma_ld_i = 0; dmem_xcpt_pf_st_i = 0; dmem_xcpt_pf_ld_i = 0;
  endtask

  task automatic set_xcpt(input int xsel);
    case (xsel)
      1: dmem_xcpt_ma_ld_i = 1;
      2: dmem_xcpt_ma_st_i = 1;
      3: dmem_xcpt_pf_ld_i = 1;
      default: dmem_xcpt_pf_st_i = 1;
    endcase
  endtask

  // One pipelined ALU/none cycle: check the previous instruction's result,
  // then present the next one.
  task automatic alu_cycle(input bit vld, input logic [1:0] unit, input logic [3:0] op,
                           input logic [63:0] a, input logic [63:0] b, input bit imm_sel,
                           input logic [4:0] rd, input logic [63:0] exp);
    logic [63:0] e;
    logic [4:0] er;
    logic [63:0] junk;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      er = rd_q.pop_front();
      check("alu_wb_valid", wb_valid_o, 1);
      check("alu_result", wb_result_o, e);
      check("alu_rd", wb_rd_o, er);
    end else begin
      check("idle_wb_valid", wb_valid_o, 0);
    end
    check("alu_no_req", dmem_req_valid_o, 0);
    check("alu_no_lock", dmem_lock_o, 0);
    junk = {$urandom, $urandom};
    valid_i = vld; unit_i = unit; alu_op_i = op; rd_i = rd; data_rs1_i = a;
    use_imm_i = imm_sel;
    if (imm_sel) begin imm_i = b; data_rs2_i = junk; end
    else begin data_rs2_i = b; imm_i = junk; end
    if (vld) begin exp_q.push_back(exp); rd_q.push_back(rd); end
  endtask

  // Check a cycle where a memory access is outstanding, then throw stray
  // instructions at the stage that must be ignored.
  task automatic busy_check(input string ph, input bit in_req, inout int lc);
    lc++;
    check({ph, "_lock"}, dmem_lock_o, 1);
    check({ph, "_req_valid"}, dmem_req_valid_o, in_req);
    check({ph, "_no_wb"}, wb_valid_o, 0);
    check({ph, "_no_kill"}, dmem_req_kill_o, 0);
    valid_i = 1'($urandom_range(0, 1));
    unit_i = 2'($urandom_range(0, 3));
    rd_i = 5'($urandom_range(0, 31));
    data_rs1_i = {$urandom, $urandom};
  endtask

  // Full memory access with the bench acting as the cache.
  task automatic run_mem(input logic [1:0] unit, input logic [1:0] size,
                         input logic [63:0] rs1, input logic [63:0] imm, input logic [63:0] rs2,
                         input logic [4:0] rd, input int ready_dly, input int resp_dly,
                         input int nacks, input logic [63:0] rdata, input int xsel,
                         input bit x_in_wait, output int lock_cycles);
    logic [63:0] full_addr;
    logic [39:0] exp_addr;
    logic [63:0] exp_res;
    bit io_exp;
    bit done;
    full_addr = rs1 + imm;
    exp_addr = full_addr[39:0];
    io_exp = (exp_addr >= io_base_addr_i);
    exp_res = (unit == U_LOAD) ? ref_load(rdata, size) : 64'd0;
    lock_cycles = 0;
    done = 0;
    @(negedge clk);
    valid_i = 1; unit_i = unit; mem_size_i = size; data_rs1_i = rs1; imm_i = imm;
    use_imm_i = 1; data_rs2_i = rs2; rd_i = rd; alu_op_i = 4'($urandom_range(0, 15));
    #1;
    check("lock_rise", dmem_lock_o, 1);
    lock_cycles++;
    @(negedge clk);
    valid_i = 0;
    check("req_addr", dmem_req_addr_o, exp_addr);
    check("req_cmd", dmem_req_cmd_o, (unit == U_STORE) ? 5'd1 : 5'd0);
    check("req_tag", dmem_req_tag_o, {rd, 3'b000});
    check("req_data", dmem_req_data_o, rs2);
    check("req_size", dmem_op_type_o, size);
    check("req_io", dbg_io_access_o, io_exp);
    check("req_inv_lr", dmem_req_invalidate_lr_o, 0);
    for (int att = 0; att <= nacks && !done; att++) begin
      busy_check("req", 1, lock_cycles);
      for (int k = 0; k < ready_dly; k++) begin
        @(negedge clk);
        busy_check("req_hold", 1, lock_cycles);
      end
      if (att == nacks && xsel != 0 && !x_in_wait) begin
        set_xcpt(xsel);
        done = 1;
      end else begin
        dmem_req_ready_i = 1;
        @(negedge clk);
        dmem_req_ready_i = 0;
        busy_check("wait", 0, lock_cycles);
        for (int k = 0; k < resp_dly; k++) begin
          @(negedge clk);
          busy_check("wait_hold", 0, lock_cycles);
        end
        if (att < nacks) begin
          if ($urandom_range(0, 1) == 1) dmem_resp_nack_i = 1;
          else dmem_resp_replay_i = 1;
          @(negedge clk);
          dmem_resp_nack_i = 0;
          dmem_resp_replay_i = 0;
        end else begin
          if (xsel != 0) set_xcpt(xsel);
          dmem_resp_valid_i = 1;
          dmem_resp_data_i = rdata;
          done = 1;
        end
      end
    end
    @(negedge clk);
    clear_resp();
    valid_i = 0;
    #1;
    check("done_wb_valid", wb_valid_o, 1);
    check("done_rd", wb_rd_o, rd);
    check("done_xcpt", wb_xcpt_o, (xsel != 0));
    if (xsel != 0) check("done_cause", wb_xcpt_cause_o, cause_of(xsel));
    else check("done_result", wb_result_o, exp_res);
    check("done_kill", dmem_req_kill_o, (xsel != 0));
    check("done_lock_low", dmem_lock_o, 0);
    check("done_req_low", dmem_req_valid_o, 0);
    @(negedge clk);
    check("single_wb", wb_valid_o, 0);
    check("kill_pulse", dmem_req_kill_o, 0);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    bit          imm;
    logic [63:0] exp;
  } alu_vec_t;
  alu_vec_t vecs[$];

  // ---------------- test sequence ----------------
  initial begin
    logic [63:0] r1, r2, r3, rnd;
    logic [3:0] op;
    int lc, xsel;
    logic [1:0] un;

    idle_inputs();
    // Reset with a memory instruction presented: everything must stay 0.
    rstn_i = 1;
    valid_i = 1;
    unit_i = U_LOAD;
    repeat (3) @(negedge clk);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_result", wb_result_o, 0);
    check("rst_wb_rd", wb_rd_o, 0);
    check("rst_wb_xcpt", wb_xcpt_o, 0);
    check("rst_cause", wb_xcpt_cause_o, 0);
    check("rst_req_valid", dmem_req_valid_o, 0);
    check("rst_lock", dmem_lock_o, 0);
    check("rst_kill", dmem_req_kill_o, 0);
    check("rst_addr", dmem_req_addr_o, 0);
    check("rst_tag", dmem_req_tag_o, 0);
    check("rst_cmd", dmem_req_cmd_o, 0);
    check("rst_data", dmem_req_data_o, 0);
    check("rst_state", dbg_state_o, 0);
    valid_i = 0;
    unit_i = U_ALU;
    rstn_i = 0;

    // Back-to-back ADD, 1000 cycles.
    for (int i = 0; i < 1000; i++)
      alu_cycle(1, U_ALU, 4'd0, 64'd24, 64'd28, 0, 5'(i), 64'd52);
    alu_cycle(0, U_ALU, 4'd0, 0, 0, 0, 0, 0);
    alu_cycle(0, U_ALU, 4'd0, 0, 0, 0, 0, 0);

    vecs.push_back('{4'd1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd4, 1, 64'hFFFF_FFFF_FFFF_FFEC});
    vecs.push_back('{4'd3, 64'hFFFF_FFFF_FFFF_FFF0, 64'd4, 1, 64'd1});
    vecs.push_back('{4'd4, 64'hFFFF_FFFF_FFFF_FFF0, 64'd4, 0, 64'd0});
    vecs.push_back('{4'd7, 64'hFFFF_FFFF_FFFF_FFF0, 64'd4, 1, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{4'd6, 64'hFFFF_FFFF_FFFF_FFF0, 64'd4, 0, 64'h0FFF_FFFF_FFFF_FFFF});
    vecs.push_back('{4'd2, 64'd1, 64'd63, 1, 64'h8000_0000_0000_0000});
    vecs.push_back('{4'd2, 64'd5, 64'd64, 0, 64'd5});
    vecs.push_back('{4'd2, 64'd1, 64'h41, 1, 64'd2});
    vecs.push_back('{4'd7, 64'h4000_0000_0000_0000, 64'd62, 0, 64'd1});
    vecs.push_back('{4'd5, 64'hF0F0, 64'h0FF0, 0, 64'hFF00});
    vecs.push_back('{4'd8, 64'hF000, 64'h000F, 1, 64'hF00F});
    vecs.push_back('{4'd9, 64'hFF00, 64'h0FF0, 0, 64'h0F00});
    vecs.push_back('{4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1, 64'd1});
    vecs.push_back('{4'd1, 64'd0, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{4'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0});
    vecs.push_back('{4'd4, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd1});
    vecs.push_back('{4'd10, 64'd7, 64'd9, 0, 64'd0});
    vecs.push_back('{4'd15, 64'd7, 64'd9, 1, 64'd0});
    for (int i = 0; i < vecs.size(); i++)
      alu_cycle(1, U_ALU, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, 5'(i + 1), vecs[i].exp);
    // unit "none" writes back 0.
    alu_cycle(1, U_NONE, 4'd0, 64'd5, 64'd7, 0, 5'd9, 64'd0);
    alu_cycle(0, U_ALU, 4'd0, 0, 0, 0, 0, 0);
    alu_cycle(0, U_ALU, 4'd0, 0, 0, 0, 0, 0);

    // Randomized ALU stream.
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      r1 = {$urandom, $urandom};
      r2 = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 127));
      alu_cycle(1, ($urandom_range(0, 9) == 0) ? U_NONE : U_ALU, op, r1, r2,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 64'd0);
      // Fix up expectation for the instruction just pushed.
      if (unit_i == U_ALU) begin
        void'(exp_q.pop_back());
        exp_q.push_back(ref_alu(op, r1, r2));
      end
    end
    alu_cycle(0, U_ALU, 4'd0, 0, 0, 0, 0, 0);
    alu_cycle(0, U_ALU, 4'd0, 0, 0, 0, 0, 0);

    // Hand-written memory sequences.
    run_mem(U_LOAD, 2'd3, 64'h1000, 64'd8, 64'd0, 5'd5, 0, 3, 0, 64'hDEAD, 0, 0, lc);
    check("load_lock_len", (lc >= 4), 1);
    run_mem(U_LOAD, 2'd0, 64'h2000, 64'd1, 64'd0, 5'd6, 0, 1, 0, 64'h80, 0, 0, lc);
    run_mem(U_LOAD, 2'd1, 64'h2000, 64'd2, 64'd0, 5'd7, 1, 0, 0, 64'h1234_8001, 0, 0, lc);
    run_mem(U_LOAD, 2'd2, 64'h2000, 64'd4, 64'd0, 5'd8, 0, 0, 0, 64'h5_8000_0001, 0, 0, lc);
    run_mem(U_LOAD, 2'd3, 64'h3000, 64'd0, 64'd0, 5'd9, 0, 1, 1, 64'h77, 0, 0, lc);
    run_mem(U_STORE, 2'd2, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFC, 64'hCAFE_F00D, 5'd10, 2, 1, 2,
            64'h99, 0, 0, lc);
    run_mem(U_LOAD, 2'd3, 64'h1001, 64'd0, 64'd0, 5'd11, 0, 2, 0, 64'h55, 1, 1, lc);
    run_mem(U_STORE, 2'd3, 64'h5000, 64'd0, 64'd1, 5'd12, 1, 0, 0, 64'h0, 4, 0, lc);
    io_base_addr_i = 40'h100;
    run_mem(U_LOAD, 2'd3, 64'h200, 64'd0, 64'd0, 5'd13, 0, 0, 0, 64'hABC, 0, 0, lc);
    io_base_addr_i = 40'hFF_0000_0000;

    // Reset while waiting on a response: no write-back may come out.
    @(negedge clk);
    valid_i = 1; unit_i = U_LOAD; data_rs1_i = 64'h40; imm_i = 0; rd_i = 5'd3; mem_size_i = 2'd3;
    @(negedge clk);
    valid_i = 0; dmem_req_ready_i = 1;
    @(negedge clk);
    dmem_req_ready_i = 0;
    check("mid_state_wait", dbg_state_o, 2);
    rstn_i = 1; dmem_resp_valid_i = 1; dmem_resp_data_i = 64'h1;
    @(negedge clk);
    rstn_i = 0; dmem_resp_valid_i = 0;
    #1;
    check("mid_rst_no_wb", wb_valid_o, 0);
    check("mid_rst_state", dbg_state_o, 0);
    check("mid_rst_lock", dmem_lock_o, 0);
    check("mid_rst_req", dmem_req_valid_o, 0);
    @(negedge clk);
    check("mid_rst_no_wb2", wb_valid_o, 0);

    // Randomized memory accesses.
    for (int n = 0; n < 80; n++) begin
      rnd = {$urandom, $urandom};
      io_base_addr_i = rnd[39:0];
      un = ($urandom_range(0, 1) == 1) ? U_STORE : U_LOAD;
      xsel = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
      r1 = {$urandom, $urandom};
      r2 = 64'($urandom_range(0, 4095));
      r3 = {$urandom, $urandom};
      rnd = {$urandom, $urandom};
      run_mem(un, 2'($urandom_range(0, 3)), r1, r2, r3, 5'($urandom_range(0, 31)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              rnd, xsel, 1'($urandom_range(0, 1)), lc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exe_stage_top.md
Name: exe_stage_top

Overview:
Execute stage of the in-order DRAC integer pipeline. Sits between register-read and write-back.
- Performs 64-bit ALU operations.
- Issues load/store requests to the data-memory interface.
- Returns one registered result record per instruction to write-back.
- Asserts a lock (stall) while a memory access is outstanding.

Parameters:
XLEN, 64, datapath width
ADDR_W, 40, memory address width
TAG_W, 8, dmem request tag width

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  reset, synchronous, active-high (1 = reset)
valid_i  in  1  instruction present from decode/register-read
unit_i  in  2  functional unit: 0=ALU, 1=LOAD, 2=STORE, 3=none
alu_op_i  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
use_imm_i  in  1  operand B = imm_i instead of data_rs2_i
imm_i  in  XLEN  sign-extended immediate
data_rs1_i  in  XLEN  source 1
data_rs2_i  in  XLEN  source 2 (store data)
rd_i  in  5  destination register
mem_size_i  in  2  0 byte, 1 half, 2 word, 3 dword
io_base_addr_i  in  ADDR_W  addresses >= this are IO (non-speculative)
dmem_req_ready_i  in  1  cache accepts request
dmem_resp_valid_i  in  1  response valid
dmem_resp_data_i  in  64  load data
dmem_resp_nack_i  in  1  request rejected, reissue
dmem_resp_replay_i  in  1  request replayed, reissue
dmem_xcpt_ma_st_i / dmem_xcpt_ma_ld_i / dmem_xcpt_pf_st_i / dmem_xcpt_pf_ld_i  in  1 each  misaligned / page-fault exceptions
dmem_req_valid_o  out  1  request valid
dmem_req_cmd_o  out  5  0 = load, 1 = store
dmem_req_addr_o  out  ADDR_W  rs1 + imm
dmem_op_type_o  out  2  = mem_size_i
dmem_req_data_o  out  64  rs2
dmem_req_tag_o  out  TAG_W  {rd_i, 3'b0}
dmem_req_invalidate_lr_o  out  1  tied 0
dmem_req_kill_o  out  1  1 for one cycle when an exception aborts a request
dmem_lock_o  out  1  stall upstream
wb_valid_o  out  1  result valid to write-back
wb_rd_o  out  5  destination
wb_result_o  out  XLEN  result
wb_xcpt_o  out  1  exception flag
wb_xcpt_cause_o  out  4  4 = ld misaligned, 6 = st misaligned, 13 = ld page fault, 15 = st page fault

Behaviour:
- Reset: all outputs are 0; the state machine goes to IDLE.
- Operand B is imm_i when use_imm_i = 1, otherwise data_rs2_i.
- ALU ops:
  - Shifts use B[5:0].
  - SLT is signed compare; SLTU is unsigned compare.
  - ADD and SUB wrap modulo 2^64.
  - Undefined alu_op codes give result 0.
- ALU path: valid_i with unit ALU gives a registered result next cycle: wb_valid_o = 1, wb_result_o, wb_rd_o. Latency is 1 cycle and throughput is 1 per cycle; no lock.
- unit none with valid_i gives wb_valid_o = 1 and result 0 next cycle.
- Memory state machine: IDLE -> REQ -> WAIT -> IDLE.
  - In IDLE, valid_i with a LOAD or STORE moves to REQ. The instruction is latched and dmem_lock_o rises in the same cycle (combinational from valid_i & mem unit).
  - In REQ, dmem_req_valid_o = 1; move to WAIT on dmem_req_ready_i.
  - In WAIT:
    - resp_valid completes the access. A load writes dmem_resp_data_i sign-extended per size; a store writes wb_valid_o with result 0.
    - nack or replay returns to REQ.
- Exceptions: any xcpt input during REQ or WAIT aborts the access.
  - dmem_req_kill_o pulses for 1 cycle.
  - wb_valid_o = 1 with wb_xcpt_o = 1 and the matching cause; the FSM returns to IDLE.
- dmem_lock_o stays high until the cycle wb_valid_o is asserted for the memory op. Inputs are ignored while locked.
- Simultaneous resp_valid and xcpt: the exception wins.
- Reset mid-access: the FSM returns to IDLE and no write-back is produced.
- IO accesses (addr >= io_base_addr_i) follow the same flow; no special ordering is required.
- All registers update on the rising clk_i edge.

Test Plan:
- ALU ADD: rs1 = 24, rs2 = 28, use_imm = 0, repeated every cycle for 1000 cycles -> each next cycle wb_valid_o = 1, wb_result_o = 52; dmem_req_valid_o stays 0.
- SUB/SLT/SRA: rs1 = 0xFFFF_FFFF_FFFF_FFF0, B = 4 -> SUB = 0x...FFEC, SLT = 1, SLTU = 0, SRA = 0xFFFF_FFFF_FFFF_FFFF.
- Load dword: rs1 = 0x1000, imm = 8, ready = 1, response 0xDEAD after 3 cycles -> dmem_req_addr_o = 0x1008, lock held 4+ cycles, wb_result_o = 0xDEAD.
- Load byte sign-extension: resp_data = 0x80, size = 0 -> wb_result_o = 0xFFFF_FFFF_FFFF_FF80.
- Nack then response: nack in WAIT -> dmem_req_valid_o re-asserts; second response completes once.
- Misaligned load exception in WAIT -> kill pulse, wb_xcpt_o = 1, cause = 4, lock drops.
